result_packer: RTL and testbench
================================

# result_packer

Downstream stage of the MAC sample controller. Collects the 8-bit quantized results the controller emits as single-cycle `t_valid` pulses and packs four consecutive results into one 32-bit word, lane 0 first. Buffers the packed words in a small FIFO and drains them to the host side over a valid/ready handshake. The controller cannot be back-pressured, so overflow is detected and flagged rather than stalled.

## Interface

- `DEPTH`, default 4: FIFO depth in 32-bit words; power of two, ≥2.
- `clk`  in  1  clock; all logic on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  result strobe; connects to controller `t_valid`; one byte per high cycle.
- `in_data`  in  8  result byte; connects to controller `out_data`; sampled when `in_valid`=1.
- `out_valid`  out  1  FIFO non-empty; `out_data` is valid.
- `out_data`  out  32  FIFO head word.
- `out_ready`  in  1  consumer accepts the head word when `out_valid`&&`out_ready`.
- `count`  out  $clog2(DEPTH)+1  number of words held.
- `full`  out  1  `count`==DEPTH.
- `overflow`  out  1  sticky; set when a completed word is dropped.
- `flush`  in  1  present only with `RESULT_PACKER_FLUSH_EN`; pushes a partial word.

## Operation

- Lane FSM states: LANE0, LANE1, LANE2, LANE3. Reset state is LANE0.
- In LANEk, `in_valid` writes `in_data` into the staging register bits [8k+7:8k] and advances to LANE(k+1).
- From LANE3, `in_valid` completes the word {in_data, stage[23:0]} and attempts a push. The FSM returns to LANE0 whether or not the push succeeds.
- A push is accepted if `count`<DEPTH, or if a pop occurs in the same cycle.
- If a push is refused, the word is discarded, `overflow` is set to 1, and the FIFO is unchanged.
- `overflow` clears only on reset.
- Pop: `out_valid`&&`out_ready` removes the head word. `out_ready` while empty is ignored.
- Simultaneous push and pop: `count` is unchanged and both take effect.
- Pointers wrap modulo DEPTH.
- The staging register is not cleared on word completion. Lanes are overwritten by later bytes.
- Reset mid-word: the partial word is discarded and the FSM returns to LANE0.
- Reset values: `out_valid`=0, `out_data`=0, `count`=0, `full`=0, `overflow`=0. The staging register, FSM and pointers are all zeroed.

## Timing

- Latency: a completing byte at edge N gives `out_valid`=1 after edge N, when the FIFO was empty.
- `out_data` shows the new head in the cycle after a pop.
- Throughput: one byte per cycle in; one word per cycle out.
- `full` and `count` are registered and update on the edge of the push or pop.
- `in_valid` may be high on consecutive cycles; there is no minimum gap.

## Configuration

- `RESULT_PACKER_FLUSH_EN` defined:
  - The `flush` port exists.
  - `flush`=1 in LANE1..LANE3 pushes the staged lanes, with unfilled upper lanes forced to 0, and returns the FSM to LANE0.
  - If `in_valid` is high in the same cycle, that byte is included first. If that byte completes the word, the result is an ordinary push.
  - Push acceptance and overflow rules are the same as for a completed word.
  - `flush` in LANE0 with no `in_valid` has no effect.
- `RESULT_PACKER_FLUSH_EN` undefined: the `flush` port and its logic are absent. Partial words persist until completed or reset.

## Structure

- Package `result_packer_pkg` holds:
  - `BYTE_W`=8
  - `LANES`=4
  - `WORD_W`=32
  - `lane_t`: the 2-bit lane state enum LANE0..LANE3
- Sub-module `sync_fifo`, parameterized on width and depth, holds the storage, pointers, `count` and `full`.
- The top level holds the lane FSM, the staging register and the overflow logic.

## Test plan

- Bytes 0x11, 0x22, 0x33, 0x44 with `out_ready`=0 -> `out_valid`=1 one cycle after the 4th byte, `out_data`=0x44332211, `count`=1.
- 4×DEPTH bytes with `out_ready`=0, then 4 more bytes -> `full`=1, the extra word is dropped, `overflow`=1. Draining then returns exactly DEPTH words, in order.
- FIFO full, 4th byte arrives in the same cycle as `out_ready`=1 -> the push is accepted, `count` stays DEPTH, `overflow` stays 0.
- 2 bytes 0xAA, 0xBB, then `rstn` pulsed low, then 0x01..0x04 -> a single word 0x04030201 and no trace of 0xAA or 0xBB.
- With `RESULT_PACKER_FLUSH_EN`: 0x5A, 0x6B, then `flush` -> `out_data`=0x00006B5A. A following `flush` alone -> no push.
- Back-to-back `in_valid` for 8 cycles with `out_ready`=1 continuously -> two words are emitted, `count` never exceeds 1, `overflow`=0.

Source files
------------

// File: rtl/result_packer_pkg.sv
// +--------------------------------------------------------------------------+
// | result_packer_pkg : shared widths and lane state for the result packer   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package result_packer_pkg;
  localparam int BYTE_W = 8;
  localparam int LANES  = 4;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    LANE0 = 2'd0,
    LANE1 = 2'd1,
    LANE2 = 2'd2,
    LANE3 = 2'd3
  } lane_t;
endpackage

`default_nettype wire

// File: rtl/result_packer_fifo.sv
// +--------------------------------------------------------------------------+
// | sync_fifo : power-of-two synchronous FIFO with registered count/full     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic                     push_ok_o,
  output logic                     out_valid_o,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             full_q;
  logic             do_pop;
  logic             do_push;

  // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
  assign do_pop    = pop_i && (count_q != '0);
  assign do_push   = push_i && (!full_q || do_pop);
  assign push_ok_o = do_push;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
    end
  end

  assign out_valid_o = (count_q != '0);
  assign data_o      = mem_q[rd_ptr_q];
  assign count_o     = count_q;
  assign full_o      = full_q;
endmodule

`default_nettype wire

// File: rtl/result_packer.sv
// +--------------------------------------------------------------------------+
// | result_packer : packs 4 result bytes per 32-bit word into a drain FIFO   |
// | Optional partial-word flush: RESULT_PACKER_FLUSH_EN          Rev 1.0     |
// +--------------------------------------------------------------------------+
`default_nettype none

module result_packer
  import result_packer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid_i,
  input  logic [BYTE_W-1:0]      in_data_i,
`ifdef RESULT_PACKER_FLUSH_EN
  input  logic                   flush_i,
`endif
  output logic                   out_valid_o,
  output logic [WORD_W-1:0]      out_data_o,
  input  logic                   out_ready_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   overflow_o
);
  lane_t             lane_q, lane_d;
  logic [WORD_W-1:0] stage_q, stage_d;
  logic [WORD_W-1:0] word_d;
  logic              push_d;
  logic              push_ok;
  logic              overflow_q;

  always_comb begin
    lane_d  = lane_q;
    stage_d = stage_q;
    push_d  = 1'b0;
    if (in_valid_i) begin
      case (lane_q)
        LANE0:   stage_d[7:0]   = in_data_i;
        LANE1:   stage_d[15:8]  = in_data_i;
        LANE2:   stage_d[23:16] = in_data_i;
        default: stage_d[31:24] = in_data_i;
      endcase
      if (lane_q == LANE3) begin
        push_d = 1'b1;
        lane_d = LANE0;
      end else begin
        lane_d = lane_t'(lane_q + 2'd1);
      end
    end
    word_d = stage_d;
`ifdef RESULT_PACKER_FLUSH_EN
    // Flush pushes only the lanes filled so far (including this cycle's byte).
    if (flush_i && !push_d && ((lane_q != LANE0) || in_valid_i)) begin
      push_d = 1'b1;
      lane_d = LANE0;
      case (lane_d == LANE0 && in_valid_i ? lane_q : lane_t'(lane_q - 2'd1))
        LANE0:   word_d = {24'h0, stage_d[7:0]};
        LANE1:   word_d = {16'h0, stage_d[15:0]};
        LANE2:   word_d = {8'h0, stage_d[23:0]};
        default: word_d = stage_d;
      endcase
    end
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lane_q     <= LANE0;
      stage_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      lane_q     <= lane_d;
      stage_q    <= stage_d;
      overflow_q <= overflow_q | (push_d & ~push_ok);
    end
  end

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .push_i      (push_d),
    .data_i      (word_d),
    .pop_i       (out_ready_i),
    .push_ok_o   (push_ok),
    .out_valid_o (out_valid_o),
    .data_o      (out_data_o),
    .count_o     (count_o),
    .full_o      (full_o)
  );

  assign overflow_o = overflow_q;
endmodule

`default_nettype wire

// File: tb/tb_result_packer.sv
// +--------------------------------------------------------------------------+
// | tb_result_packer : scoreboard bench for result_packer                    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_result_packer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic [2:0]  count;
  logic        full;
  logic        overflow;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q [$];
  logic [31:0] mon_exp;
  logic [31:0] w;
  int          max_cnt;

  always #5 clk = ~clk;

  result_packer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
`ifdef RESULT_PACKER_FLUSH_EN
    .flush_i     (flush),
`endif
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_ready_i (out_ready),
    .count_o     (count),
    .full_o      (full),
    .overflow_o  (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted head word must match the scoreboard front.
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_unexpected: actual %h required no word", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pop_data", out_data, mon_exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (count == 3'd0) break;
    end
    out_ready = 1'b0;
    check("drain_done_count", {29'h0, count}, 32'h0);
  endtask

  // Four bytes of word k in a fill sequence, lane 0 = base+4k.
  task automatic send_word(input logic [7:0] base, input int k, input bit expect_push);
    logic [7:0] b0, b1, b2, b3;
    b0 = base + 8'(4 * k);
    b1 = b0 + 8'd1;
    b2 = b0 + 8'd2;
    b3 = b0 + 8'd3;
    if (expect_push) exp_q.push_back({b3, b2, b1, b0});
    send(b0);
    send(b1);
    send(b2);
    send(b3);
  endtask

  initial begin
    do_reset();
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_count", {29'h0, count}, 32'h0);
    check("rst_full", {31'h0, full}, 32'h0);
    check("rst_overflow", {31'h0, overflow}, 32'h0);

    // Basic packing, lane 0 first
    exp_q.push_back(32'h44332211);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    check("t1_valid_before", {31'h0, out_valid}, 32'h0);
    send(8'h44);
    check("t1_out_valid", {31'h0, out_valid}, 32'h1);
    check("t1_out_data", out_data, 32'h44332211);
    check("t1_count", {29'h0, count}, 32'h1);
    drain();

    // Fill to full, then one dropped word
    for (int k = 0; k < DEPTH; k++) send_word(8'h10, k, 1'b1);
    check("t2_full", {31'h0, full}, 32'h1);
    check("t2_count", {29'h0, count}, 32'(DEPTH));
    check("t2_ovf_before", {31'h0, overflow}, 32'h0);
    send_word(8'h10, DEPTH, 1'b0);
    check("t2_overflow", {31'h0, overflow}, 32'h1);
    check("t2_count_after", {29'h0, count}, 32'(DEPTH));
    drain();
    check("t2_sb_empty", 32'(exp_q.size()), 32'h0);
    check("t2_ovf_sticky", {31'h0, overflow}, 32'h1);

    // Full FIFO, completing byte coincides with a pop
    do_reset();
    check("t3_ovf_cleared", {31'h0, overflow}, 32'h0);
    for (int k = 0; k < DEPTH; k++) send_word(8'h40, k, 1'b1);
    exp_q.push_back(32'hA3A2A1A0);
    send(8'hA0);
    send(8'hA1);
    send(8'hA2);
    out_ready = 1'b1;
    send(8'hA3);
    out_ready = 1'b0;
    check("t3_count", {29'h0, count}, 32'(DEPTH));
    check("t3_full", {31'h0, full}, 32'h1);
    check("t3_overflow", {31'h0, overflow}, 32'h0);
    drain();

    // Reset mid-word discards the partial word
    send(8'hAA);
    send(8'hBB);
    do_reset();
    exp_q.push_back(32'h04030201);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    send(8'h04);
    check("t4_count", {29'h0, count}, 32'h1);
    check("t4_out_data", out_data, 32'h04030201);
    drain();

`ifdef RESULT_PACKER_FLUSH_EN
    exp_q.push_back(32'h00006B5A);
    send(8'h5A);
    send(8'h6B);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t5_count", {29'h0, count}, 32'h1);
    check("t5_out_data", out_data, 32'h00006B5A);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t5_flush_idle", {29'h0, count}, 32'h1);
    drain();
`endif

    // Back-to-back bytes with continuous ready
    out_ready = 1'b1;
    max_cnt = 0;
    exp_q.push_back(32'h84838281);
    exp_q.push_back(32'h88878685);
    for (int i = 1; i <= 8; i++) begin
      w = 32'h80 + 32'(i);
      send(w[7:0]);
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
    out_ready = 1'b0;
    check("t6_max_count", 32'(max_cnt), 32'h1);
    check("t6_overflow", {31'h0, overflow}, 32'h0);
    check("t6_count_end", {29'h0, count}, 32'h0);
    check("final_sb_empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1);
  end
endmodule

`default_nettype wire
